mmcm_drp_ctrl: RTL and testbench
================================

MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 Parameter RST_HOLD, default 4: cycles mmcm_rst is held asserted before the first DRP access.
REQ-002 Parameter DRP_TIMEOUT, default 64: maximum cycles to wait for drdy after a den pulse.
REQ-003 Parameter LOCK_TIMEOUT, default 65536: maximum cycles to wait for lock after mmcm_rst is released.
REQ-004 The block SHALL have one clock, clk_100m; reset is asynchronous and active-low, named rst_n.
REQ-005 clk_100m  in  1  DRP and controller clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cmd_valid  in  1  DRP write command present.
REQ-008 cmd_ready  out  1  command accepted this cycle.
REQ-009 cmd_addr  in  7  DRP register address.
REQ-010 cmd_data  in  16  new bit values.
REQ-011 cmd_mask  in  16  1 = keep the existing bit, 0 = take the bit from cmd_data.
REQ-012 cmd_last  in  1  final command of the reconfiguration sequence.
REQ-013 daddr  out  7  DRP address.
REQ-014 den  out  1  DRP enable, one-cycle pulse.
REQ-015 dwe  out  1  DRP write enable.
REQ-016 di  out  16  DRP write data.
REQ-017 do_in  in  16  DRP read data.
REQ-018 drdy  in  1  DRP ready.
REQ-019 mmcm_rst  out  1  MMCM reset, active-high.
REQ-020 mmcm_locked  in  1  raw MMCM LOCKED, asynchronous to clk_100m.
REQ-021 busy  out  1  sequence in progress.
REQ-022 done  out  1  one-cycle pulse on successful completion.
REQ-023 err  out  2  sticky error code: 0 none, 1 DRP timeout, 2 lock timeout, 3 lock lost.
REQ-024 cfg_locked  out  1  synchronized lock status.

Function
REQ-025 mmcm_locked SHALL pass through a 2-flop synchronizer; cfg_locked SHALL be the second flop.
REQ-026 States: IDLE, RST_HOLD, WAIT_CMD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, WAIT_LOCK.
REQ-027 IDLE: cmd_ready=0, busy=0. When cmd_valid=1, the block SHALL assert mmcm_rst, clear err, and enter RST_HOLD.
REQ-028 RST_HOLD: the block SHALL count RST_HOLD cycles, then enter WAIT_CMD.
REQ-029 WAIT_CMD: cmd_ready=1. A transfer occurs on cmd_valid & cmd_ready. On transfer, the block SHALL latch addr, data, mask and last, then enter RD_REQ. cmd_ready SHALL be 0 in every other state.
REQ-030 RD_REQ: the block SHALL drive den=1, dwe=0, daddr=latched address for exactly one cycle, then enter RD_WAIT.
REQ-031 RD_WAIT: on drdy, the block SHALL set di = (do_in & mask) | (cmd_data & ~mask) and enter WR_REQ.
REQ-032 WR_REQ: the block SHALL drive den=1, dwe=1 for exactly one cycle, then enter WR_WAIT.
REQ-033 WR_WAIT: on drdy, the block SHALL enter RELEASE if last=1, else WAIT_CMD.
REQ-034 RD_WAIT/WR_WAIT: if drdy is absent for DRP_TIMEOUT cycles after den, the block SHALL set err=1, leave mmcm_rst asserted, and return to IDLE.
REQ-035 RELEASE: the block SHALL deassert mmcm_rst for one cycle and enter WAIT_LOCK.
REQ-036 WAIT_LOCK: when cfg_locked=1, the block SHALL pulse done and enter IDLE. If LOCK_TIMEOUT cycles elapse first, it SHALL set err=2 and enter IDLE.
REQ-037 busy SHALL be 1 in every state except IDLE.
REQ-038 In IDLE, a falling edge of cfg_locked after a successful done SHALL set err=3 (sticky) while the block stays in IDLE.
REQ-039 mmcm_rst SHALL stay asserted continuously from RST_HOLD through WR_WAIT.
REQ-040 drdy arriving outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-041 Timeout counters SHALL reload on each state entry and SHALL NOT wrap.
REQ-042 den SHALL never be asserted on two consecutive cycles.

Reset
REQ-043 While rst_n=0, all of the following SHALL hold asynchronously: state=IDLE, mmcm_rst=1, den=0, dwe=0, daddr=0, di=0, cmd_ready=0, busy=0, done=0, err=0, and both synchronizer flops=0.
REQ-044 After rst_n rises, mmcm_rst SHALL fall one cycle later. This is the power-on release; no lock timeout applies.
REQ-045 Reset asserted mid-sequence SHALL abort the sequence with no further DRP access.

Verification
REQ-046 Single command: addr 0x08, data 0x1041, mask 0x1000, last=1; DRP model returns 0xF0F0, drdy 3 cycles after den -> di=0x1041, done pulses once lock is modelled, err=0.
REQ-047 Three commands, last on the third -> exactly 3 reads and 3 writes; mmcm_rst high throughout and released after the third write.
REQ-048 drdy never returned -> err=1 exactly DRP_TIMEOUT cycles after den; busy=0; mmcm_rst stays 1.
REQ-049 Lock never asserts -> err=2 after LOCK_TIMEOUT cycles; no done pulse.
REQ-050 Lock drops after done -> err=3 three cycles later; a new cmd_valid clears err.
REQ-051 rst_n pulsed low during RD_WAIT -> all outputs at reset values immediately; no den afterwards.

Source files
------------

// File: rtl/mmcm_drp_ctrl_if.sv
// Purpose: command handshake and DRP bus between a reconfiguration master
//          and mmcm_drp_ctrl.
// Ports (slave = controller view):
//   cmd_valid/cmd_ready  write-command handshake
//   cmd_addr/data/mask   register address, new bits, keep-mask (1 = keep)
//   cmd_last             final command of the sequence
//   daddr/den/dwe/di     DRP request side
//   do_in/drdy           DRP response side
interface mmcm_drp_ctrl_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_mask;
    logic              cmd_last;
    logic [ADDR_W-1:0] daddr;
    logic              den;
    logic              dwe;
    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] do_in;
    logic              drdy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_data, cmd_mask, cmd_last, do_in, drdy,
        output cmd_ready, daddr, den, dwe, di
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_data, cmd_mask, cmd_last, do_in, drdy,
        input  cmd_ready, daddr, den, dwe, di
    );
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// Purpose: holds an MMCM in reset, applies a sequence of masked
//          read-modify-write DRP accesses, releases reset and waits for lock.
// Ports:
//   clk_100m, rst_n  clock, asynchronous active-low reset
//   bus              command handshake + DRP bus (slave modport)
//   mmcm_rst         MMCM reset, active-high
//   mmcm_locked      raw LOCKED, asynchronous
//   busy, done       sequence in progress / one-cycle success pulse
//   err              sticky code: 0 none, 1 DRP timeout, 2 lock timeout, 3 lock lost
//   cfg_locked       synchronized lock status
module mmcm_drp_ctrl #(
    parameter int unsigned RST_HOLD     = 4,
    parameter int unsigned DRP_TIMEOUT  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic                 clk_100m,
    input  logic                 rst_n,
    mmcm_drp_ctrl_if.slave       bus,
    output logic                 mmcm_rst,
    input  logic                 mmcm_locked,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err,
    output logic                 cfg_locked
);
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned MAX_A   = (RST_HOLD > DRP_TIMEOUT) ? RST_HOLD : DRP_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    // Wait states are entered one cycle after the event they time from,
    // so loads are two short of the budget to land the timeout exactly.
    localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] DRP_LOAD  = CNT_W'(DRP_TIMEOUT - 2);
    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_TIMEOUT - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_HOLD, S_WAIT_CMD, S_RD_REQ, S_RD_WAIT,
        S_WR_REQ, S_WR_WAIT, S_RELEASE, S_WAIT_LOCK
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_dec;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, r_daddr, w_daddr_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt, r_mask, w_mask_nxt, r_di, w_di_nxt;
    logic              r_last, w_last_nxt;
    logic              r_den, w_den_nxt, r_dwe, w_dwe_nxt;
    logic              r_mmcm_rst, w_rst_nxt;
    logic              r_cmd_ready, w_ready_nxt, r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;
    logic [1:0]        r_err, w_err_nxt;
    logic              r_armed, w_armed_nxt;
    logic              r_sync1, r_sync2, r_lock_q;
    logic              r_por;

    assign w_cnt_dec = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;

    // State and output registers
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_last      <= 1'b0;
            r_daddr     <= '0;
            r_di        <= '0;
            r_den       <= 1'b0;
            r_dwe       <= 1'b0;
            r_mmcm_rst  <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'd0;
            r_armed     <= 1'b0;
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_lock_q    <= 1'b0;
            r_por       <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_mask      <= w_mask_nxt;
            r_last      <= w_last_nxt;
            r_daddr     <= w_daddr_nxt;
            r_di        <= w_di_nxt;
            r_den       <= w_den_nxt;
            r_dwe       <= w_dwe_nxt;
            r_mmcm_rst  <= w_rst_nxt;
            r_cmd_ready <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_armed     <= w_armed_nxt;
            r_sync1     <= mmcm_locked;
            r_sync2     <= r_sync1;
            r_lock_q    <= r_sync2;
            r_por       <= 1'b0;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_mask_nxt  = r_mask;
        w_last_nxt  = r_last;
        w_daddr_nxt = r_daddr;
        w_di_nxt    = r_di;
        w_den_nxt   = 1'b0;
        w_dwe_nxt   = 1'b0;
        w_rst_nxt   = r_mmcm_rst;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        w_armed_nxt = r_armed;
        w_ready_nxt = 1'b0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Power-on release; after a DRP timeout reset stays held.
                if (r_por) w_rst_nxt = 1'b0;
                if (r_armed && r_lock_q && !r_sync2) begin
                    w_err_nxt   = 2'd3;
                    w_armed_nxt = 1'b0;
                end
                if (bus.cmd_valid) begin
                    w_state_nxt = S_RST_HOLD;
                    w_rst_nxt   = 1'b1;
                    w_err_nxt   = 2'd0;
                    w_armed_nxt = 1'b0;
                    w_cnt_nxt   = RST_LOAD;
                end
            end
            S_RST_HOLD: begin
                if (r_cnt == '0) w_state_nxt = S_WAIT_CMD;
                else             w_cnt_nxt   = w_cnt_dec;
            end
            S_WAIT_CMD: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_addr_nxt  = bus.cmd_addr;
                    w_data_nxt  = bus.cmd_data;
                    w_mask_nxt  = bus.cmd_mask;
                    w_last_nxt  = bus.cmd_last;
                    w_daddr_nxt = bus.cmd_addr;
                    w_den_nxt   = 1'b1;
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                w_state_nxt = S_RD_WAIT;
                w_cnt_nxt   = DRP_LOAD;
            end
            S_RD_WAIT: begin
                if (bus.drdy) begin
                    w_di_nxt    = (bus.do_in & r_mask) | (r_data & ~r_mask);
                    w_den_nxt   = 1'b1;
                    w_dwe_nxt   = 1'b1;
                    w_state_nxt = S_WR_REQ;
                end else if (r_cnt == '0) begin
                    w_err_nxt   = 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            S_WR_REQ: begin
                w_state_nxt = S_WR_WAIT;
                w_cnt_nxt   = DRP_LOAD;
            end
            S_WR_WAIT: begin
                if (bus.drdy) begin
                    if (r_last) begin
                        w_state_nxt = S_RELEASE;
                        w_rst_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_WAIT_CMD;
                    end
                end else if (r_cnt == '0) begin
                    w_err_nxt   = 2'd1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_WAIT_LOCK;
                w_cnt_nxt   = LOCK_LOAD;
            end
            S_WAIT_LOCK: begin
                if (r_sync2) begin
                    w_done_nxt  = 1'b1;
                    w_armed_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_err_nxt   = 2'd2;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt   = w_cnt_dec;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_ready_nxt = (w_state_nxt == S_WAIT_CMD);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.daddr     = r_daddr;
    assign bus.den       = r_den;
    assign bus.dwe       = r_dwe;
    assign bus.di        = r_di;
    assign mmcm_rst      = r_mmcm_rst;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign cfg_locked    = r_sync2;
endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// Purpose: scoreboard bench for mmcm_drp_ctrl with a DRP register model
//          and a simple MMCM lock model.
module tb_mmcm_drp_ctrl;
    localparam int unsigned DRP_TO  = 64;
    localparam int unsigned LOCK_TO = 256;
    localparam int EV_RD   = 0;
    localparam int EV_WR   = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    logic       clk_100m = 1'b0;
    logic       rst_n    = 1'b0;
    logic       mmcm_rst, mmcm_locked, busy, done, cfg_locked;
    logic [1:0] err;

    mmcm_drp_ctrl_if bus ();

    mmcm_drp_ctrl #(
        .RST_HOLD     (4),
        .DRP_TIMEOUT  (DRP_TO),
        .LOCK_TIMEOUT (LOCK_TO)
    ) dut (
        .clk_100m    (clk_100m),
        .rst_n       (rst_n),
        .bus         (bus),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cfg_locked  (cfg_locked)
    );

    always #5 clk_100m = ~clk_100m;

    typedef struct {
        int kind;
        int addr;
        int data;
        int dt;
    } ev_t;

    ev_t         sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    logic        drp_mute = 1'b0;
    logic        lock_en  = 1'b1;
    logic [15:0] mem [0:127];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int addr, input int data, input int dt);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.dt = dt;
        sb.push_back(e);
    endtask

    // Compare one observed DUT event against the head of the scoreboard.
    task automatic observe(input int kind, input int addr, input int data, input int dt, input logic rst);
        ev_t e;
        logic ok;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: got kind %0d addr 0x%0h data 0x%0h, expected no event (cycle %0d)",
                     kind, addr, data, cyc);
            return;
        end
        e  = sb.pop_front();
        ok = (e.kind == kind);
        if (kind == EV_RD)   ok = ok && (e.addr == addr) && rst;
        if (kind == EV_WR)   ok = ok && (e.addr == addr) && (e.data == data) && rst;
        if (kind == EV_DONE) ok = ok && !rst;
        if (kind == EV_ERR)  ok = ok && (e.data == data) && (e.dt == dt);
        if (!ok) begin
            n_bad++;
            $display("FAIL sb_event: got kind %0d addr 0x%0h data 0x%0h dt %0d rst %0b, expected kind %0d addr 0x%0h data 0x%0h dt %0d (cycle %0d)",
                     kind, addr, data, dt, rst, e.kind, e.addr, e.data, e.dt, cyc);
        end
    endtask

    // Monitor: every DRP strobe, done pulse and new error is an event.
    logic [1:0] prev_err  = 2'd0;
    logic       prev_rst  = 1'b1;
    logic       prev_lock = 1'b0;
    int         last_den = 0, last_fall = 0, last_lockfall = 0;

    always @(posedge clk_100m) cyc <= cyc + 1;

    always @(negedge clk_100m) begin
        if (rst_n) begin
            if (!mmcm_rst && prev_rst) last_fall = cyc;
            if (!mmcm_locked && prev_lock) last_lockfall = cyc;
            if (bus.den) begin
                last_den = cyc;
                observe(bus.dwe ? EV_WR : EV_RD, int'(32'(bus.daddr)), int'(32'(bus.di)), 0, mmcm_rst);
            end
            if (done) observe(EV_DONE, 0, 0, 0, mmcm_rst);
            if (err != 2'd0 && prev_err == 2'd0)
                observe(EV_ERR, 0, int'(32'(err)),
                        cyc - ((err == 2'd1) ? last_den : (err == 2'd2) ? last_fall : last_lockfall),
                        mmcm_rst);
        end
        prev_err  = err;
        prev_rst  = mmcm_rst;
        prev_lock = mmcm_locked;
    end

    // DRP register model: drdy three cycles after den.
    initial begin
        logic [6:0]  a;
        logic [15:0] wd;
        logic        we;
        bus.drdy  = 1'b0;
        bus.do_in = 16'h0;
        forever begin
            @(negedge clk_100m);
            if (rst_n && bus.den && !drp_mute) begin
                a  = bus.daddr;
                we = bus.dwe;
                wd = bus.di;
                repeat (2) @(posedge clk_100m);
                #1;
                if (we) mem[a] = wd;
                bus.do_in = mem[a];
                bus.drdy  = 1'b1;
                @(posedge clk_100m);
                #1 bus.drdy = 1'b0;
            end
        end
    end

    // MMCM model: locks five cycles after reset is released.
    initial begin
        int lcnt;
        lcnt        = 0;
        mmcm_locked = 1'b0;
        forever begin
            @(posedge clk_100m);
            #1;
            if (mmcm_rst || !lock_en) lcnt = 0;
            else if (lcnt < 5)        lcnt++;
            mmcm_locked = (lcnt >= 5);
        end
    end

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] d, input logic [15:0] m, input logic l);
        int n;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_mask  = m;
        bus.cmd_last  = l;
        bus.cmd_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!bus.cmd_ready && n < 200);
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk_100m);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (busy && n < bound);
        check(name, 32'(busy), 32'd0);
        repeat (3) @(negedge clk_100m);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_mask  = '0;
        bus.cmd_last  = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0;
        mem[8'h08] = 16'hF0F0;
        mem[8'h09] = 16'h1234;
        mem[8'h0A] = 16'hA5A5;

        // Reset values
        repeat (3) @(negedge clk_100m);
        check("rst_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check("rst_den", 32'(bus.den), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_cfg_locked", 32'(cfg_locked), 32'd0);
        @(posedge clk_100m);
        #1 rst_n = 1'b1;
        @(negedge clk_100m);
        check("por_hold", 32'(mmcm_rst), 32'd1);
        @(negedge clk_100m);
        check("por_release", 32'(mmcm_rst), 32'd0);
        repeat (20) @(negedge clk_100m);
        check("por_cfg_locked", 32'(cfg_locked), 32'd1);

        // Single command: (F0F0 & 1000) | (1041 & EFFF) = 1041
        expect_ev(EV_RD, 'h08, 0, 0);
        expect_ev(EV_WR, 'h08, 'h1041, 0);
        expect_ev(EV_DONE, 0, 0, 0);
        send_cmd(7'h08, 16'h1041, 16'h1000, 1'b1);
        wait_idle("t1_idle", 500);
        check("t1_err", 32'(err), 32'd0);
        check("t1_drain", 32'(sb.size()), 32'd0);

        // Three commands: 12AA, F5F5, 1040
        expect_ev(EV_RD, 'h09, 0, 0);
        expect_ev(EV_WR, 'h09, 'h12AA, 0);
        expect_ev(EV_RD, 'h0A, 0, 0);
        expect_ev(EV_WR, 'h0A, 'hF5F5, 0);
        expect_ev(EV_RD, 'h08, 0, 0);
        expect_ev(EV_WR, 'h08, 'h1040, 0);
        expect_ev(EV_DONE, 0, 0, 0);
        send_cmd(7'h09, 16'h00AA, 16'hFF00, 1'b0);
        send_cmd(7'h0A, 16'hFFFF, 16'h0F0F, 1'b0);
        send_cmd(7'h08, 16'h0000, 16'hFFF0, 1'b1);
        wait_idle("t2_idle", 500);
        check("t2_err", 32'(err), 32'd0);
        check("t2_drain", 32'(sb.size()), 32'd0);

        // DRP timeout on the read
        drp_mute = 1'b1;
        expect_ev(EV_RD, 'h10, 0, 0);
        expect_ev(EV_ERR, 0, 1, DRP_TO);
        send_cmd(7'h10, 16'h0001, 16'h0000, 1'b1);
        wait_idle("t3_idle", 500);
        check("t3_err", 32'(err), 32'd1);
        check("t3_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check("t3_drain", 32'(sb.size()), 32'd0);
        drp_mute = 1'b0;

        // Lock never arrives: (0 & 00FF) | (3C3C & FF00) = 3C00
        lock_en = 1'b0;
        expect_ev(EV_RD, 'h11, 0, 0);
        expect_ev(EV_WR, 'h11, 'h3C00, 0);
        expect_ev(EV_ERR, 0, 2, LOCK_TO);
        send_cmd(7'h11, 16'h3C3C, 16'h00FF, 1'b1);
        wait_idle("t4_idle", 2000);
        check("t4_err", 32'(err), 32'd2);
        check("t4_drain", 32'(sb.size()), 32'd0);

        // Lock lost after done, then cleared by a new command
        lock_en = 1'b1;
        repeat (10) @(negedge clk_100m);
        expect_ev(EV_RD, 'h12, 0, 0);
        expect_ev(EV_WR, 'h12, 'hBEEF, 0);
        expect_ev(EV_DONE, 0, 0, 0);
        send_cmd(7'h12, 16'hBEEF, 16'h0000, 1'b1);
        wait_idle("t5_idle", 500);
        repeat (5) @(negedge clk_100m);
        check("t5_err_before_drop", 32'(err), 32'd0);
        expect_ev(EV_ERR, 0, 3, 3);
        @(posedge clk_100m);
        #1 lock_en = 1'b0;
        repeat (10) @(negedge clk_100m);
        check("t5_err_lost", 32'(err), 32'd3);
        lock_en = 1'b1;
        repeat (10) @(negedge clk_100m);
        check("t5_err_sticky", 32'(err), 32'd3);
        expect_ev(EV_RD, 'h13, 0, 0);
        expect_ev(EV_WR, 'h13, 'h0001, 0);
        expect_ev(EV_DONE, 0, 0, 0);
        send_cmd(7'h13, 16'h0001, 16'h0000, 1'b1);
        check("t5_err_cleared", 32'(err), 32'd0);
        wait_idle("t5b_idle", 500);
        check("t5_drain", 32'(sb.size()), 32'd0);

        // Reset during RD_WAIT
        drp_mute = 1'b1;
        expect_ev(EV_RD, 'h14, 0, 0);
        send_cmd(7'h14, 16'h7777, 16'h0000, 1'b1);
        n = 0;
        while (!bus.den && n < 50) begin
            @(negedge clk_100m);
            n++;
        end
        check("t6_den_seen", 32'(bus.den), 32'd1);
        repeat (2) @(negedge clk_100m);
        #2 rst_n = 1'b0;
        #1;
        check("t6_mmcm_rst", 32'(mmcm_rst), 32'd1);
        check("t6_den", 32'(bus.den), 32'd0);
        check("t6_dwe", 32'(bus.dwe), 32'd0);
        check("t6_daddr", 32'(bus.daddr), 32'd0);
        check("t6_di", 32'(bus.di), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_err", 32'(err), 32'd0);
        check("t6_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("t6_cfg_locked", 32'(cfg_locked), 32'd0);
        repeat (3) @(negedge clk_100m);
        @(posedge clk_100m);
        #1 rst_n = 1'b1;
        drp_mute = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_100m);
            if (bus.den) n++;
        end
        check("t6_no_den", 32'(n), 32'd0);
        check("t6_busy_after", 32'(busy), 32'd0);
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
